// File: rtl/demux_dispatch_credit_rr_pkg.sv
// Shared types and helpers for the credit round-robin dispatcher
// and the bus demux it feeds.
package demux_dispatch_credit_rr_pkg;

  localparam int unsigned CREDIT_T_W = 8;
  localparam int unsigned MAX_LANES  = 64;

  typedef logic [CREDIT_T_W-1:0] credit_t;

  function automatic int unsigned onehot_to_idx(
    input logic [MAX_LANES-1:0] oh
  );
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/demux_dispatch_credit_rr_arb.sv
// Combinational round-robin arbiter: first request at or above ptr,
// wrapping, wins a one-hot grant.
module arbiter_round_robin_one_hot #(
  parameter int unsigned N     = 8,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[PTR_W'(idx)]) begin
        grant[PTR_W'(idx)] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_credit_rr.sv
// Credit-based round-robin dispatcher driving the one-hot bus demux;
// lanes return credits as their buffers drain.
module demux_dispatch_credit_rr
  import demux_dispatch_credit_rr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned SEL_WIDTH    = BUS_WIDTH,
  parameter int unsigned CREDIT_MAX   = 4,
  parameter int unsigned CREDIT_WIDTH = $clog2(CREDIT_MAX + 1)
) (
  input  logic                  ap_clk,
  input  logic                  areset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [BUS_WIDTH-1:0]  s_mask,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BUS_WIDTH-1:0]  credit_return,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [SEL_WIDTH-1:0]  sel_out,
  output logic [BUS_WIDTH-1:0]  data_out_valid,
  output logic                  credit_overflow
);

  localparam int unsigned PTR_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CREDIT_WIDTH-1:0] CMAX = CREDIT_WIDTH'(CREDIT_MAX);

  if (SEL_WIDTH != BUS_WIDTH) begin : g_sel_chk
    $error("SEL_WIDTH must equal BUS_WIDTH");
  end
  if (CREDIT_WIDTH > $bits(credit_t)) begin : g_cw_chk
    $error("CREDIT_WIDTH exceeds shared credit_t");
  end

  logic [CREDIT_WIDTH-1:0] credit_q [BUS_WIDTH];
  logic [CREDIT_WIDTH-1:0] credit_d [BUS_WIDTH];
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    ovf_q, ovf_d;

  logic [BUS_WIDTH-1:0] has_credit;
  logic [BUS_WIDTH-1:0] eligible;
  logic [BUS_WIDTH-1:0] grant;
  logic [BUS_WIDTH-1:0] grant_eff;
  logic                 accept;

  always_comb begin
    has_credit = '0;
    for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
      has_credit[i] = (credit_q[i] != '0);
    end
  end

  assign eligible  = s_mask & has_credit;
  assign s_ready   = |eligible;
  assign accept    = s_valid & s_ready;
  assign grant_eff = accept ? grant : '0;

  arbiter_round_robin_one_hot #(
    .N     (BUS_WIDTH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Grant and return on the same lane cancel out.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
      credit_d[i] = credit_q[i];
      case ({grant_eff[i], credit_return[i]})
        2'b10: credit_d[i] = credit_q[i] - CREDIT_WIDTH'(1);
        2'b01: begin
          if (credit_q[i] == CMAX) ovf_d = 1'b1;
          else credit_d[i] = credit_q[i] + CREDIT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = grant_eff;
    if (accept) begin
      data_d   = s_data;
      rr_ptr_d = PTR_W'((onehot_to_idx(64'(grant)) + 1) % BUS_WIDTH);
    end
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < BUS_WIDTH; i++) credit_q[i] <= CMAX;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < BUS_WIDTH; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign data_out        = data_q;
  assign sel_out         = sel_q;
  assign data_out_valid  = sel_q;
  assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_demux_dispatch_credit_rr.sv
// Scoreboard bench for demux_dispatch_credit_rr: directed beats push
// expected outputs, a monitor pops them as lanes go valid.
module tb_demux_dispatch_credit_rr;

  localparam int DW = 32;
  localparam int BW = 4;

  logic          ap_clk = 1'b0;
  logic          areset_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [BW-1:0] s_mask = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] credit_return = '0;
  logic [DW-1:0] data_out;
  logic [BW-1:0] sel_out;
  logic [BW-1:0] data_out_valid;
  logic          credit_overflow;

  typedef struct {
    logic [DW-1:0] d;
    logic [BW-1:0] g;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  demux_dispatch_credit_rr #(
    .DATA_WIDTH (DW),
    .BUS_WIDTH  (BW),
    .SEL_WIDTH  (BW),
    .CREDIT_MAX (2)
  ) dut (
    .ap_clk          (ap_clk),
    .areset_n        (areset_n),
    .s_data          (s_data),
    .s_mask          (s_mask),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .credit_return   (credit_return),
    .data_out        (data_out),
    .sel_out         (sel_out),
    .data_out_valid  (data_out_valid),
    .credit_overflow (credit_overflow)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented lane-valid must match the next queued beat.
  always @(negedge ap_clk) begin
    exp_t e;
    if (areset_n && data_out_valid != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: dov=%b data=%h none expected",
                 data_out_valid, data_out);
      end else begin
        e = q.pop_front();
        if (data_out !== e.d || sel_out !== e.g ||
            data_out_valid !== e.g || cyc != e.cyc) begin
          errors++;
          $display("FAIL beat: data=%h sel=%b dov=%b cyc=%0d expected data=%h grant=%b cyc=%0d",
                   data_out, sel_out, data_out_valid, cyc, e.d, e.g, e.cyc);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [BW-1:0] m,
                      input logic [DW-1:0] d, input logic [BW-1:0] cr,
                      input logic er, input logic [BW-1:0] eg);
    exp_t e;
    @(negedge ap_clk);
    s_valid       = v;
    s_mask        = m;
    s_data        = d;
    credit_return = cr;
    #1;
    chk("s_ready", 64'(s_ready), 64'(er));
    if (v && er) begin
      e.d   = d;
      e.g   = eg;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    s_valid       = 1'b0;
    credit_return = '0;
    areset_n      = 1'b0;
    repeat (2) @(negedge ap_clk);
    areset_n = 1'b1;
  endtask

  task automatic full_round(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111, base + DW'(i), '0, 1'b1, BW'(1 << (i % 4)));
    end
    step(1'b1, 4'b1111, base + 32'h99, '0, 1'b0, '0);
  endtask

  initial begin
    // reset state, credits full so ready with any mask
    s_mask = 4'b1111;
    #12;
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_sel_out", 64'(sel_out), 64'h0);
    chk("rst_dov", 64'(data_out_valid), 64'h0);
    chk("rst_ovf", 64'(credit_overflow), 64'h0);
    chk("rst_ready", 64'(s_ready), 64'h1);
    @(negedge ap_clk);
    areset_n = 1'b1;

    // eight grants rotate 0..3 twice, then all credits gone
    full_round(32'hA000_0000);

    // refill all lanes to 2
    step(1'b0, '0, '0, 4'b1111, 1'b0, '0);
    step(1'b0, '0, '0, 4'b1111, 1'b0, '0);

    // lane 2 unicast: A,B go, C waits on a returned credit
    step(1'b1, 4'b0100, 32'hAAAA_0001, '0, 1'b1, 4'b0100);
    step(1'b1, 4'b0100, 32'hBBBB_0002, '0, 1'b1, 4'b0100);
    step(1'b1, 4'b0100, 32'hCCCC_0003, '0, 1'b0, '0);
    step(1'b1, 4'b0100, 32'hCCCC_0003, 4'b0100, 1'b0, '0);
    step(1'b1, 4'b0100, 32'hCCCC_0003, '0, 1'b1, 4'b0100);

    // lane 1: grant plus return in one cycle leaves credit at 1
    step(1'b1, 4'b0010, 32'hD000_0001, '0, 1'b1, 4'b0010);
    step(1'b1, 4'b0010, 32'hD000_0002, 4'b0010, 1'b1, 4'b0010);
    step(1'b1, 4'b0010, 32'hD000_0003, '0, 1'b1, 4'b0010);
    step(1'b1, 4'b0010, 32'hD000_0004, '0, 1'b0, '0);

    // empty mask stalls, no output, credits untouched
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000, 32'hE000_0000 + DW'(i), '0, 1'b0, '0);
      chk("mask0_dov", 64'(data_out_valid), 64'h0);
    end
    step(1'b1, 4'b0001, 32'hF000_0001, '0, 1'b1, 4'b0001);
    step(1'b1, 4'b0001, 32'hF000_0002, '0, 1'b1, 4'b0001);
    step(1'b1, 4'b0001, 32'hF000_0003, '0, 1'b0, '0);
    chk("no_ovf_yet", 64'(credit_overflow), 64'h0);

    // return to a full lane: saturates and sets sticky overflow
    do_reset();
    step(1'b0, '0, '0, 4'b0001, 1'b0, '0);
    chk("ovf_same_cycle", 64'(credit_overflow), 64'h0);
    step(1'b1, 4'b0001, 32'h0F0F_0001, '0, 1'b1, 4'b0001);
    chk("ovf_set", 64'(credit_overflow), 64'h1);
    step(1'b1, 4'b0001, 32'h0F0F_0002, '0, 1'b1, 4'b0001);
    step(1'b1, 4'b0001, 32'h0F0F_0003, '0, 1'b0, '0);
    idle();
    chk("ovf_sticky", 64'(credit_overflow), 64'h1);

    // async reset while lane 1 output is valid
    do_reset();
    chk("ovf_cleared", 64'(credit_overflow), 64'h0);
    step(1'b1, 4'b0010, 32'h5151_5151, '0, 1'b1, 4'b0010);
    @(negedge ap_clk);
    s_valid = 1'b0;
    s_mask  = '0;
    #2;
    chk("pre_rst_dov", 64'(data_out_valid), 64'h2);
    areset_n = 1'b0;
    #1;
    chk("async_dov", 64'(data_out_valid), 64'h0);
    chk("async_sel", 64'(sel_out), 64'h0);
    chk("async_data", 64'(data_out), 64'h0);
    @(negedge ap_clk);
    areset_n = 1'b1;

    // every lane back to 2 credits
    full_round(32'hB000_0000);

    idle();
    idle();
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
